// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use bubble, mul/div EX occupancy stall with timeout, taken-branch squash.
// Optional perf counters (stall_count/flush_count) are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
  input  logic                  IF_ID_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  ID_EX_MemRead,
  input  logic                  md_start,
  input  logic                  md_done,
  input  logic                  branch_taken,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic                  EX_MEM_Flush,
  output logic                  md_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  localparam int MDC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state, state_nx;
  logic [MDC_W-1:0] md_cnt, md_cnt_nx;
  logic             timeout_set;
  logic             load_use;
  logic             md_expire;
  logic             branch_flush;

  assign load_use = ID_EX_MemRead && (ID_EX_rd != '0) &&
                    ((ID_EX_rd == IF_ID_rs1) || (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

  assign md_expire = (state == MD_BUSY) && !md_done && (md_cnt == MD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      md_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
      if (timeout_set) md_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    md_cnt_nx   = md_cnt;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (md_start && !md_done) begin
          state_nx  = MD_BUSY;
          md_cnt_nx = MDC_W'(1);
        end
      end
      MD_BUSY: begin
        if (md_done) begin
          state_nx  = RUN;
          md_cnt_nx = '0;
        end else if (md_expire) begin
          state_nx    = RUN;
          md_cnt_nx   = '0;
          timeout_set = 1'b1;
        end else if (md_cnt != '1) begin
          md_cnt_nx = md_cnt + MDC_W'(1);
        end
      end
      default: begin
        state_nx  = RUN;
        md_cnt_nx = '0;
      end
    endcase
  end

  // Reset pattern is driven straight from rst_n so the pipeline freezes without waiting for a clock.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    branch_flush = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (md_start && !md_done) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
          end else if (branch_taken && !md_start) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            branch_flush = 1'b1;
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        MD_BUSY: begin
          // Timed-out result is dropped by bubbling EX/MEM on the releasing cycle.
          if (md_done) begin
            EX_MEM_Flush = 1'b0;
          end else if (md_expire) begin
            EX_MEM_Flush = 1'b1;
          end else begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!PCWrite && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (branch_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule
